// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and encodings for the data-memory bridge.
//   SZ_*         : access size encodings from the M stage
//   dmem_state_t : bridge FSM states
//   bus_cmd_t    : registered bus command payload (we/addr/be/wdata)
package dmem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane logic for the data-memory bridge.
//   addr_lo   in  : byte offset within the word
//   size      in  : access size (SZ_*; 11 behaves as word)
//   sign      in  : sign-extend loads when 1
//   wdata_in  in  : right-justified store data
//   rdata_in  in  : raw bus read word
//   be        out : little-endian byte enables
//   wdata_out out : store data replicated across lanes
//   rdata_out out : selected and extended load data
//   mis       out : access is misaligned for its size
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic [XLEN-1:0] wdata_in,
  input  logic [XLEN-1:0] rdata_in,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_out,
  output logic [XLEN-1:0] rdata_out,
  output logic            mis
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane selection from the read word.
  always_comb begin
    rbyte = rdata_in[7:0];
    case (addr_lo)
      2'd1:    rbyte = rdata_in[15:8];
      2'd2:    rbyte = rdata_in[23:16];
      2'd3:    rbyte = rdata_in[31:24];
      default: rbyte = rdata_in[7:0];
    endcase
    rhalf = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];
  end

  // Size-dependent enables, replication, extension and alignment check.
  always_comb begin
    be        = '1;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    mis       = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = BE_W'(1) << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{sign & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        mis       = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {{16{sign & rhalf[15]}}, rhalf};
      end
      default: begin
        mis = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: M-stage to req/ack data bus bridge with stall, alignment
// faults and bus timeout.
//   clk, rst                      : clock, synchronous active-high reset
//   memreqM/memwriteM/memsizeM/
//   memsignM/aluoutM/writedataM   : M-stage access
//   readdataM, buserrM            : registered load result / timeout flag (DONE)
//   stallM, adelM, adesM          : combinational stall and misalignment flags
//   bus_req/we/addr/be/wdata      : registered bus command
//   bus_ack, bus_rdata            : bus completion and read data
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            memreqM,
  input  logic            memwriteM,
  input  logic [1:0]      memsizeM,
  input  logic            memsignM,
  input  logic [XLEN-1:0] aluoutM,
  input  logic [XLEN-1:0] writedataM,
  output logic [XLEN-1:0] readdataM,
  output logic            stallM,
  output logic            adelM,
  output logic            adesM,
  output logic            buserrM,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  dmem_state_t     state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  bus_cmd_t        cmd_q, cmd_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            buserr_q, buserr_d;

  logic [BE_W-1:0] lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_rdata;
  logic            mis;

  dmem_align u_align (
    .addr_lo   (aluoutM[1:0]),
    .size      (memsizeM),
    .sign      (memsignM),
    .wdata_in  (writedataM),
    .rdata_in  (bus_rdata),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata),
    .mis       (mis)
  );

  // Next-state, bus command and combinational pipeline flags.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cmd_d    = cmd_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    buserr_d = buserr_q;
    case (state_q)
      IDLE: begin
        if (memreqM && !mis) begin
          state_d     = BUSY;
          req_d       = 1'b1;
          wait_d      = '0;
          cmd_d.we    = memwriteM;
          cmd_d.addr  = {aluoutM[XLEN-1:2], 2'b00};
          cmd_d.be    = lane_be;
          cmd_d.wdata = lane_wdata;
        end
      end
      BUSY: begin
        // Ack has priority over a timeout in the same cycle.
        if (bus_ack && req_q) begin
          state_d  = DONE;
          req_d    = 1'b0;
          rdata_d  = lane_rdata;
          buserr_d = 1'b0;
        end else if (wait_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d  = DONE;
          req_d    = 1'b0;
          rdata_d  = '0;
          buserr_d = 1'b1;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Pipeline advances this cycle, so the access cannot retrigger.
        state_d  = IDLE;
        buserr_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    stallM = !rst && (((state_q == IDLE) && memreqM && !mis) || (state_q == BUSY));
    adelM  = !rst && (state_q == IDLE) && memreqM && !memwriteM && mis;
    adesM  = !rst && (state_q == IDLE) && memreqM && memwriteM && mis;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      cmd_q    <= '0;
      req_q    <= 1'b0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cmd_q    <= cmd_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = cmd_q.we;
  assign bus_addr  = cmd_q.addr;
  assign bus_be    = cmd_q.be;
  assign bus_wdata = cmd_q.wdata;
  assign readdataM = rdata_q;
  assign buserrM   = buserr_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed and randomized checks of dmem_bridge against an
// arithmetic reference model of the lane, stall and timeout rules.
module tb_dmem_bridge;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreqM, memwriteM, memsignM;
  logic [1:0]  memsizeM;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic        stallM, adelM, adesM, buserrM;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int tests = 0;
  int fails = 0;

  dmem_bridge #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .memreqM(memreqM), .memwriteM(memwriteM), .memsizeM(memsizeM),
    .memsignM(memsignM), .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM),
    .buserrM(buserrM), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic logic mis_of(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 4'(1 << int'(a[1:0]));
    if (sz == 2'b01) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] rdata_of(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One M-stage access; waits = BUSY cycles before ack (<0 or >=MW: never acks).
  task automatic do_access(input string nm, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits);
    int   stalls = 0;
    int   busy = 0;
    bit   fin = 1'b0;
    bit   tmo;
    int   exp_busy;
    logic m;
    m        = mis_of(sz, a);
    tmo      = !(waits >= 0 && waits < int'(MW));
    exp_busy = tmo ? int'(MW) : waits + 1;
    memreqM = 1'b1; memwriteM = we; memsizeM = sz; memsignM = sg;
    aluoutM = a; writedataM = wd; bus_rdata = rd; bus_ack = 1'b0;
    if (m) begin
      #1;
      chk({nm, " adelM"}, 32'(adelM), 32'(!we));
      chk({nm, " adesM"}, 32'(adesM), 32'(we));
      chk({nm, " mis_stall"}, 32'(stallM), 32'd0);
      @(posedge clk); #1;
      chk({nm, " mis_no_req"}, 32'(bus_req), 32'd0);
      chk({nm, " mis_stall2"}, 32'(stallM), 32'd0);
    end else begin
      for (int c = 0; c < 4 * int'(MW) + 10 && !fin; c++) begin
        if (bus_req) begin
          chk({nm, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
          chk({nm, " bus_be"}, 32'(bus_be), 32'(be_of(sz, a)));
          chk({nm, " bus_we"}, 32'(bus_we), 32'(we));
          chk({nm, " bus_wdata"}, bus_wdata, wdata_of(sz, wd));
          bus_ack = (busy == waits);
          busy++;
        end else begin
          bus_ack = 1'b0;
        end
        #1;
        if (stallM) begin
          stalls++;
          @(posedge clk); #1;
        end else begin
          fin = 1'b1;
          chk({nm, " stall_cycles"}, 32'(stalls), 32'(exp_busy + 1));
          chk({nm, " busy_cycles"}, 32'(busy), 32'(exp_busy));
          chk({nm, " done_req"}, 32'(bus_req), 32'd0);
          chk({nm, " buserrM"}, 32'(buserrM), 32'(tmo));
          if (tmo) chk({nm, " readdataM"}, readdataM, 32'd0);
          else if (!we) chk({nm, " readdataM"}, readdataM, rdata_of(sz, sg, a, rd));
        end
      end
      if (!fin) chk({nm, " done_reached"}, 32'd0, 32'd1);
    end
    memreqM = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic        r_we, r_sg;
    logic [1:0]  r_sz;
    logic [31:0] r_a, r_wd, r_rd;

    rst = 1'b1; memreqM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; memsignM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst stallM", 32'(stallM), 32'd0);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    chk("rst readdataM", readdataM, 32'd0);
    chk("rst buserrM", 32'(buserrM), 32'd0);
    memreqM = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    do_access("sw_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    do_access("lb_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 3);
    do_access("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 32'h0, 1);
    do_access("lhu_22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hABCD_0000, 2);
    do_access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 0);
    do_access("sh_mis", 1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 32'h0, 0);
    do_access("lw_tmo", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h5555_AAAA, -1);

    // Late ack in IDLE is ignored.
    bus_ack = 1'b1;
    #1;
    chk("late_ack stallM", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("late_ack bus_req", 32'(bus_req), 32'd0);
    chk("late_ack buserrM", 32'(buserrM), 32'd0);

    do_access("lw_ack_at_tmo", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h1357_9BDF, int'(MW) - 1);

    // Reset during the second BUSY cycle.
    memreqM = 1'b1; memwriteM = 1'b1; memsizeM = 2'b10; aluoutM = 32'h200;
    writedataM = 32'h1234_5678; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstbusy req_before", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstbusy bus_req", 32'(bus_req), 32'd0);
    chk("rstbusy bus_we", 32'(bus_we), 32'd0);
    chk("rstbusy bus_addr", bus_addr, 32'd0);
    chk("rstbusy bus_be", 32'(bus_be), 32'd0);
    chk("rstbusy bus_wdata", bus_wdata, 32'd0);
    chk("rstbusy readdataM", readdataM, 32'd0);
    chk("rstbusy buserrM", 32'(buserrM), 32'd0);
    chk("rstbusy stallM", 32'(stallM), 32'd0);
    rst = 1'b0; memreqM = 1'b0; bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("rstbusy ack_req", 32'(bus_req), 32'd0);
    chk("rstbusy ack_stall", 32'(stallM), 32'd0);
    chk("rstbusy ack_rdata", readdataM, 32'd0);
    chk("rstbusy ack_err", 32'(buserrM), 32'd0);

    // Randomized accesses, including misaligned ones and timeouts.
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_sg = 1'($urandom_range(0, 1));
      r_a  = $urandom;
      r_wd = $urandom;
      r_rd = $urandom;
      do_access("rand", r_we, r_sz, r_sg, r_a, r_wd, r_rd, int'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the pipeline's memory stage and a multi-cycle data SRAM/bus. It converts the core's M-stage access (address, store data, write flag, size) into a registered req/ack bus transaction with byte enables, and holds the pipeline with `stallM` until the access completes. It returns aligned and extended load data, and flags misaligned addresses and bus timeouts.

## Interface
Parameters:
- `MAX_WAIT`, 255: number of BUSY cycles without `bus_ack` before the access is aborted with `buserrM`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `memreqM` in 1: the M-stage instruction is a load or store.
- `memwriteM` in 1: 1 = store, 0 = load.
- `memsizeM` in 2: access size. 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `memsignM` in 1: load is sign-extended; 0 = zero-extended.
- `aluoutM` in 32: byte address.
- `writedataM` in 32: store data, right-justified.
- `readdataM` out 32: aligned and extended load data, valid in DONE.
- `stallM` out 1: freeze IF through M; combinational.
- `adelM` out 1: misaligned load; combinational.
- `adesM` out 1: misaligned store; combinational.
- `buserrM` out 1: timeout abort, valid in DONE.
- `bus_req` out 1: request; registered.
- `bus_we` out 1: write strobe; registered.
- `bus_addr` out 32: word address, `{aluoutM[31:2],2'b00}`; registered.
- `bus_be` out 4: byte enables, little-endian; registered.
- `bus_wdata` out 32: lane-replicated store data; registered.
- `bus_ack` in 1: completion. It is sampled only while `bus_req` is high.
- `bus_rdata` in 32: read word, valid with `bus_ack`.

## Operation
- **Alignment:** `mis` = (half and `addr[0]`) or (word and `addr[1:0]`≠0).
  - `adelM` = `memreqM & !memwriteM & mis`, only in IDLE.
  - `adesM` = `memreqM & memwriteM & mis`, only in IDLE.
  - A misaligned access starts no bus transaction and does not stall.
- **Byte enables:**
  - Byte: `be = 1<<addr[1:0]`; `wdata` = byte replicated ×4.
  - Half: `be = addr[1] ? 1100 : 0011`; `wdata` = half replicated ×2.
  - Word: `be = 1111`; `wdata` unchanged.
- **Load data:** select the lane given by `addr[1:0]` and size, then sign-extend or zero-extend per `memsignM`. The result is latched into the `readdataM` register on the ack edge.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE → BUSY: when `memreqM & !mis`. On that edge, load `bus_addr`, `bus_be`, `bus_we` and `bus_wdata`, set `bus_req`=1, and clear the wait counter.
  - BUSY → DONE: on `bus_ack`. Clear `bus_req`, latch read data, `buserrM`=0.
  - BUSY → DONE: on wait counter = `MAX_WAIT`-1 with no ack. Clear `bus_req`, `readdataM`=0, `buserrM`=1.
  - DONE → IDLE: unconditionally. The pipeline advances at the end of DONE, so the same instruction never retriggers.
- **stallM** = (IDLE & `memreqM` & !`mis`) | BUSY. `stallM` is 0 in DONE.
- **bus_req:** stays high and the bus fields stay stable until ack; the bridge never withdraws a request.
- **bus_ack** outside BUSY is ignored.
- **Reset values:** state IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `readdataM`=0, `buserrM`=0, wait counter 0. `stallM`, `adelM` and `adesM` are 0 while `rst`=1.

## Timing
- **Zero-wait bus** (ack in the first request cycle):
  - Cycle 0: IDLE, `stallM`=1.
  - Cycle 1: BUSY, `bus_req`=1, ack.
  - Cycle 2: DONE, `stallM`=0, data valid.
  - Result: 2 stall cycles.
- **General case:** stall cycles = 2 + number of wait cycles before ack.
- **Back-to-back accesses:** DONE → IDLE → BUSY, so consecutive accesses each cost the same.
- **Reset mid-BUSY:** IDLE on the next edge and `bus_req`=0. An ack arriving afterwards is ignored, and the aborted store is not retried.
- **Timeout:** abort occurs after exactly `MAX_WAIT` BUSY cycles. `buserrM` is high for one cycle, in DONE.
- **Ack and timeout in the same cycle:** ack wins and `buserrM`=0.

## Structure
- Package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum `dmem_state_t` (IDLE, BUSY, DONE).
- Sub-module `dmem_align` (combinational):
  - inputs: addr[1:0], size, sign, wdata, rdata;
  - outputs: `be`, replicated wdata, extended rdata, `mis`.
- FSM, wait counter and registers live in `dmem_bridge`.

## Test plan
- Word store at 0x100 with data 0xDEADBEEF, ack in the first request cycle:
  - expect `bus_addr`=0x100, `be`=1111, `bus_we`=1, `wdata`=0xDEADBEEF;
  - `stallM` high for exactly 2 cycles.
- Signed byte load at 0x103, `bus_rdata`=0x80FF1234, ack after 3 wait cycles:
  - expect `be`=1000 and `readdataM`=0xFFFFFF80 in DONE;
  - `stallM` high for 5 cycles.
- Half store of 0xABCD at 0x22:
  - expect `bus_addr`=0x20, `be`=1100, `wdata`=0xABCDABCD;
  - an unsigned half load from the same address with rdata 0xABCD0000 gives 0x0000ABCD.
- Misaligned accesses:
  - word load at 0x102 → `adelM`=1, `stallM`=0, no `bus_req`;
  - half store at 0x101 → `adesM`=1, no `bus_req`.
- Timeout with `MAX_WAIT`=4 and ack never asserted:
  - `bus_req` high for 4 cycles, then DONE with `buserrM`=1 and `readdataM`=0;
  - a late ack in IDLE is ignored.
- `rst` asserted in the second BUSY cycle:
  - next cycle IDLE, `bus_req`=0, all outputs at reset values;
  - an ack in the following cycle causes no state change.
